axi4_rr_arbiter_2to1: RTL

//  Shares one AXI4 manager port between two requesters: m0 (instruction fetch) and m1 (load/store).

---
 rtl/axi4_pkg.sv | 24 ++
 rtl/axi4_rr_arbiter_2to1_if.sv | 70 +++++++
 rtl/rr_grant2.sv | 18 +
 rtl/axi4_rr_arbiter_2to1.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_pkg.sv
// Shared AXI4 definitions for the 2:1 round-robin arbiter slice.
package axi4_pkg;

  localparam int DEF_ID_W   = 4;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 64;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_ADDR = 2'd1,
    WR_DATA = 2'd2,
    WR_RESP = 2'd3
  } wr_state_e;

endpackage

// File: rtl/axi4_rr_arbiter_2to1_if.sv
// One AXI4 port: the five channels, with a manager-side (master) and a
// subordinate-side (slave) view.
interface axi4_rr_arbiter_2to1_if #(
  parameter int ID_W   = axi4_pkg::DEF_ID_W,
  parameter int ADDR_W = axi4_pkg::DEF_ADDR_W,
  parameter int DATA_W = axi4_pkg::DEF_DATA_W
);
  localparam int STRB_W = DATA_W / 8;

  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid;
  logic              rready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  logic              awvalid;
  logic              awready;
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;

  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;

  logic              bvalid;
  logic              bready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;

  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready,
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready,
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready
  );

endinterface

// File: rtl/rr_grant2.sv
// Two-requester round-robin pick: returns the index of the winner.
module rr_grant2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       gnt
);

  // A contested request goes to the pointer; otherwise to whoever is asking.
  always_comb begin
    gnt = 1'b0;
    if (req == 2'b11) begin
      gnt = ptr;
    end else if (req[1]) begin
      gnt = 1'b1;
    end
  end

endmodule

// File: rtl/axi4_rr_arbiter_2to1.sv
// Shares one AXI4 manager port between m0 (fetch) and m1 (load/store).
// Reads and writes are arbitrated independently; a grant is held for a
// whole transaction and routing depends only on the registered grant.
module axi4_rr_arbiter_2to1
  import axi4_pkg::*;
#(
  parameter int ID_W   = DEF_ID_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                          clock,
  input  logic                          reset,
  axi4_rr_arbiter_2to1_if.slave         m0,
  axi4_rr_arbiter_2to1_if.slave         m1,
  axi4_rr_arbiter_2to1_if.master        out
);

  localparam int STRB_W = DATA_W / 8;

  rd_state_e rd_state_q, rd_state_d;
  logic      rgrant_q, rgrant_d;
  logic      rr_ptr_q, rr_ptr_d;
  logic      rd_pick;

  wr_state_e wr_state_q, wr_state_d;
  logic      wgrant_q, wgrant_d;
  logic      wr_ptr_q, wr_ptr_d;
  logic      wr_pick;

  logic              sel_arvalid;
  logic [ID_W-1:0]   sel_arid;
  logic [ADDR_W-1:0] sel_araddr;
  logic [7:0]        sel_arlen;
  logic [2:0]        sel_arsize;
  logic [1:0]        sel_arburst;
  logic              sel_rready;

  logic              sel_awvalid;
  logic [ID_W-1:0]   sel_awid;
  logic [ADDR_W-1:0] sel_awaddr;
  logic [7:0]        sel_awlen;
  logic [2:0]        sel_awsize;
  logic [1:0]        sel_awburst;
  logic              sel_wvalid;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_wstrb;
  logic              sel_wlast;
  logic              sel_bready;

  logic ar_hs, r_done, aw_hs, w_done, b_hs;

  rr_grant2 u_rd_pick (
    .req ({m1.arvalid, m0.arvalid}),
    .ptr (rr_ptr_q),
    .gnt (rd_pick)
  );

  rr_grant2 u_wr_pick (
    .req ({m1.awvalid, m0.awvalid}),
    .ptr (wr_ptr_q),
    .gnt (wr_pick)
  );

  // Read-side registers: FSM state, grant owner and round-robin pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state_q <= RD_IDLE;
      rgrant_q   <= 1'b0;
      rr_ptr_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rgrant_q   <= rgrant_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // Read FSM next state and AR/R routing; nothing is forwarded while idle.
  always_comb begin
    rd_state_d  = rd_state_q;
    rgrant_d    = rgrant_q;
    rr_ptr_d    = rr_ptr_q;
    ar_hs       = 1'b0;
    r_done      = 1'b0;

    sel_arvalid = rgrant_q ? m1.arvalid : m0.arvalid;
    sel_arid    = rgrant_q ? m1.arid    : m0.arid;
    sel_araddr  = rgrant_q ? m1.araddr  : m0.araddr;
    sel_arlen   = rgrant_q ? m1.arlen   : m0.arlen;
    sel_arsize  = rgrant_q ? m1.arsize  : m0.arsize;
    sel_arburst = rgrant_q ? m1.arburst : m0.arburst;
    sel_rready  = rgrant_q ? m1.rready  : m0.rready;

    out.arvalid = 1'b0;
    out.arid    = '0;
    out.araddr  = '0;
    out.arlen   = '0;
    out.arsize  = '0;
    out.arburst = '0;
    out.rready  = 1'b0;

    m0.arready = 1'b0;
    m1.arready = 1'b0;
    m0.rvalid  = 1'b0;
    m0.rid     = '0;
    m0.rdata   = '0;
    m0.rresp   = '0;
    m0.rlast   = 1'b0;
    m1.rvalid  = 1'b0;
    m1.rid     = '0;
    m1.rdata   = '0;
    m1.rresp   = '0;
    m1.rlast   = 1'b0;

    case (rd_state_q)
      RD_IDLE: begin
        if (m0.arvalid || m1.arvalid) begin
          rgrant_d   = rd_pick;
          rd_state_d = RD_ADDR;
        end
      end
      RD_ADDR: begin
        out.arvalid = sel_arvalid;
        out.arid    = sel_arid;
        out.araddr  = sel_araddr;
        out.arlen   = sel_arlen;
        out.arsize  = sel_arsize;
        out.arburst = sel_arburst;
        m0.arready  = ~rgrant_q & out.arready;
        m1.arready  = rgrant_q & out.arready;
        ar_hs       = sel_arvalid & out.arready;
        if (ar_hs) begin
          rd_state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        out.rready = sel_rready;
        if (rgrant_q) begin
          m1.rvalid = out.rvalid;
          m1.rid    = out.rid;
          m1.rdata  = out.rdata;
          m1.rresp  = out.rresp;
          m1.rlast  = out.rlast;
        end else begin
          m0.rvalid = out.rvalid;
          m0.rid    = out.rid;
          m0.rdata  = out.rdata;
          m0.rresp  = out.rresp;
          m0.rlast  = out.rlast;
        end
        r_done = out.rvalid & sel_rready & out.rlast;
        if (r_done) begin
          rr_ptr_d   = ~rgrant_q;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Write-side registers: FSM state, grant owner and round-robin pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state_q <= WR_IDLE;
      wgrant_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wgrant_q   <= wgrant_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Write FSM next state and AW/W/B routing; W is only opened after AW is accepted.
  always_comb begin
    wr_state_d  = wr_state_q;
    wgrant_d    = wgrant_q;
    wr_ptr_d    = wr_ptr_q;
    aw_hs       = 1'b0;
    w_done      = 1'b0;
    b_hs        = 1'b0;

    sel_awvalid = wgrant_q ? m1.awvalid : m0.awvalid;
    sel_awid    = wgrant_q ? m1.awid    : m0.awid;
    sel_awaddr  = wgrant_q ? m1.awaddr  : m0.awaddr;
    sel_awlen   = wgrant_q ? m1.awlen   : m0.awlen;
    sel_awsize  = wgrant_q ? m1.awsize  : m0.awsize;
    sel_awburst = wgrant_q ? m1.awburst : m0.awburst;
    sel_wvalid  = wgrant_q ? m1.wvalid  : m0.wvalid;
    sel_wdata   = wgrant_q ? m1.wdata   : m0.wdata;
    sel_wstrb   = wgrant_q ? m1.wstrb   : m0.wstrb;
    sel_wlast   = wgrant_q ? m1.wlast   : m0.wlast;
    sel_bready  = wgrant_q ? m1.bready  : m0.bready;

    out.awvalid = 1'b0;
    out.awid    = '0;
    out.awaddr  = '0;
    out.awlen   = '0;
    out.awsize  = '0;
    out.awburst = '0;
    out.wvalid  = 1'b0;
    out.wdata   = '0;
    out.wstrb   = '0;
    out.wlast   = 1'b0;
    out.bready  = 1'b0;

    m0.awready = 1'b0;
    m1.awready = 1'b0;
    m0.wready  = 1'b0;
    m1.wready  = 1'b0;
    m0.bvalid  = 1'b0;
    m0.bid     = '0;
    m0.bresp   = '0;
    m1.bvalid  = 1'b0;
    m1.bid     = '0;
    m1.bresp   = '0;

    case (wr_state_q)
      WR_IDLE: begin
        if (m0.awvalid || m1.awvalid) begin
          wgrant_d   = wr_pick;
          wr_state_d = WR_ADDR;
        end
      end
      WR_ADDR: begin
        out.awvalid = sel_awvalid;
        out.awid    = sel_awid;
        out.awaddr  = sel_awaddr;
        out.awlen   = sel_awlen;
        out.awsize  = sel_awsize;
        out.awburst = sel_awburst;
        m0.awready  = ~wgrant_q & out.awready;
        m1.awready  = wgrant_q & out.awready;
        aw_hs       = sel_awvalid & out.awready;
        if (aw_hs) begin
          wr_state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        out.wvalid = sel_wvalid;
        out.wdata  = sel_wdata;
        out.wstrb  = sel_wstrb;
        out.wlast  = sel_wlast;
        m0.wready  = ~wgrant_q & out.wready;
        m1.wready  = wgrant_q & out.wready;
        w_done     = sel_wvalid & out.wready & sel_wlast;
        if (w_done) begin
          wr_state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        out.bready = sel_bready;
        if (wgrant_q) begin
          m1.bvalid = out.bvalid;
          m1.bid    = out.bid;
          m1.bresp  = out.bresp;
        end else begin
          m0.bvalid = out.bvalid;
          m0.bid    = out.bid;
          m0.bresp  = out.bresp;
        end
        b_hs = out.bvalid & sel_bready;
        if (b_hs) begin
          wr_ptr_d   = ~wgrant_q;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

endmodule
